// File: rtl/apb_mem_slave.sv
// ---------------------------------------------------------------------------
// apb_mem_slave
//
// APB slave that fronts a small register-file memory of DEPTH words, each
// 21 bits wide. A transfer is one setup cycle followed by one or more access
// cycles. The address, direction and write data are captured at the setup
// edge, so the master may change PADDR/PWDATA during the access phase
// without affecting the transfer. Addresses at or beyond DEPTH complete
// with PSLVERR set, return zero read data and never modify memory.
//
// Configuration macro: APB_SLV_WAIT_EN
//   defined   : a wait counter inserts WAIT_CYCLES wait states per transfer
//   undefined : every transfer is zero-wait and WAIT_CYCLES is ignored
//
// Parameters
//   DEPTH       number of 21-bit words, 1..256
//   WAIT_CYCLES access-phase wait states per transfer, 0..15
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset, also clears the memory
//   PSEL     in   slave select
//   PENABLE  in   access-phase strobe
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   [7:0]  word address
//   PWDATA   in   [20:0] write data
//   PRDATA   out  [20:0] read data, zero unless a good read is completing
//   PREADY   out  transfer complete (combinational)
//   PSLVERR  out  transfer error, meaningful only while PREADY is high
// ---------------------------------------------------------------------------
module apb_mem_slave #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [20:0] PWDATA,
  output logic [20:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_W   = 9'(DEPTH);

  // Elaboration-time range checks; an out-of-range parameter creates a
  // visibly named empty scope that shows up in the hierarchy.
  if (DEPTH < 1 || DEPTH > 256) begin : g_bad_depth
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
  end

  logic [0:0]  state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic        write_q, write_d;
  logic [20:0] wdata_q, wdata_d;
  logic [3:0]  count_q;
  logic [20:0] mem_q [DEPTH];
  logic [20:0] mem_d [DEPTH];

  logic          addr_err;
  logic          commit;
  logic [AW-1:0] mem_idx;

`ifdef APB_SLV_WAIT_EN
  logic [3:0] count_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
`else
  // Without the wait feature the counter is a constant zero, so PREADY
  // rises in the first access cycle of every transfer.
  assign count_q = '0;
`endif

  assign addr_err = ({1'b0, addr_q} >= DEPTH_W);
  assign mem_idx  = addr_q[AW-1:0];

  // Completion qualification and error/read-data outputs, all combinational
  // so they drop immediately on reset or when the master releases PSEL.
  always_comb begin
    PREADY  = (state_q == ST_ACCESS) && (count_q == 4'd0) && PSEL && PENABLE;
    PSLVERR = PREADY && addr_err;
    commit  = PREADY && write_q && !addr_err;
    PRDATA  = '0;
    if (PREADY && !write_q && !addr_err) begin
      PRDATA = mem_q[mem_idx];
    end
  end

  // Next-state logic. An access phase with PSEL low is treated as a master
  // abort; PSEL high with PENABLE low while in ACCESS simply holds.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
`ifdef APB_SLV_WAIT_EN
    count_d = count_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ST_ACCESS;
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
`ifdef APB_SLV_WAIT_EN
          count_d = 4'(WAIT_CYCLES);
`endif
        end
      end
      default: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else if (PENABLE) begin
          if (count_q == 4'd0) begin
            state_d = ST_IDLE;
          end else begin
`ifdef APB_SLV_WAIT_EN
            count_d = count_q - 4'd1;
`endif
          end
        end
      end
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (commit) begin
      mem_d[mem_idx] = wdata_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_mem_slave
//
// Directed bench for apb_mem_slave (DEPTH=64, WAIT_CYCLES=2). The expected
// access-phase length follows APB_SLV_WAIT_EN: WAIT_CYCLES+1 cycles when the
// macro is defined, one cycle otherwise. Inputs change #1 after a rising
// edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_apb_mem_slave;

  localparam int DEPTH       = 64;
  localparam int WAIT_CYCLES = 2;
`ifdef APB_SLV_WAIT_EN
  localparam int EXP_WAIT = WAIT_CYCLES;
`else
  localparam int EXP_WAIT = 0;
`endif
  localparam int EXP_LAT = EXP_WAIT + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [20:0] PWDATA;
  logic [20:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int nChecks = 0;
  int nPass   = 0;

  apb_mem_slave #(
    .DEPTH      (DEPTH),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 clk = ~clk;

  // One comparison: counts it, and reports tag/observed/expected on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) nPass++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  // One complete APB transfer: setup, then access until PREADY. PADDR and
  // PWDATA are scrambled during access so a slave that fails to hold its
  // captured values is exposed. Returns at the falling edge of the
  // completion cycle so a following call runs back-to-back.
  task automatic applyStimulus(input logic wr, input logic [7:0] addr,
                               input logic [20:0] wdata,
                               output logic [20:0] rdata, output logic err,
                               output int cycles);
    logic done;
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(negedge clk);
    checkOutput("setup_pready", {31'b0, PREADY}, 32'd0);
    @(posedge clk); #1;
    PENABLE = 1'b1; PADDR = ~addr; PWDATA = ~wdata;
    cycles = 0; rdata = '0; err = 1'b0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      cycles++;
      if (PREADY) begin
        rdata = PRDATA; err = PSLVERR; done = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!done) checkOutput("pready_timeout", 32'd0, 32'd1);
  endtask

  task automatic idleCycle();
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge clk);
  endtask

  task automatic doWrite(input string tag, input logic [7:0] addr,
                         input logic [20:0] wdata, input logic expErr);
    logic [20:0] rd; logic er; int cyc;
    applyStimulus(1'b1, addr, wdata, rd, er, cyc);
    checkOutput({tag, "_lat"}, 32'(cyc), 32'(EXP_LAT));
    checkOutput({tag, "_err"}, {31'b0, er}, {31'b0, expErr});
  endtask

  task automatic doRead(input string tag, input logic [7:0] addr,
                        input logic [20:0] expData, input logic expErr);
    logic [20:0] rd; logic er; int cyc;
    applyStimulus(1'b0, addr, 21'h0, rd, er, cyc);
    checkOutput({tag, "_lat"}, 32'(cyc), 32'(EXP_LAT));
    checkOutput({tag, "_data"}, {11'b0, rd}, {11'b0, expData});
    checkOutput({tag, "_err"}, {31'b0, er}, {31'b0, expErr});
  endtask

  initial begin
    reset = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;

    // Reset state
    @(negedge clk);
    checkOutput("rst_pready", {31'b0, PREADY}, 32'd0);
    checkOutput("rst_pslverr", {31'b0, PSLVERR}, 32'd0);
    checkOutput("rst_prdata", {11'b0, PRDATA}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single write/read with wait states
    doWrite("wr05", 8'h05, 21'h1ABCD, 1'b0);
    doRead("rd05", 8'h05, 21'h1ABCD, 1'b0);

    // Back-to-back writes then reads
    for (int i = 0; i < 4; i++) doWrite("b2b_wr", 8'(i), 21'h0A5A0 + 21'(i), 1'b0);
    for (int i = 0; i < 4; i++) doRead("b2b_rd", 8'(i), 21'h0A5A0 + 21'(i), 1'b0);

    // Out-of-range write: error for exactly the completion cycle
    doWrite("oor_wr", 8'h40, 21'h0000F, 1'b1);
    idleCycle();
    checkOutput("oor_err_after", {31'b0, PSLVERR}, 32'd0);
    doRead("oor_rd00", 8'h00, 21'h0A5A0, 1'b0);
    doRead("oor_rd40", 8'h40, 21'h0, 1'b1);
    idleCycle();

    // Reset during the access phase of a write to 0x10
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h10; PWDATA = 21'h15555;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    if (EXP_WAIT >= 1) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkOutput("prerst_pready", {31'b0, PREADY}, (EXP_WAIT == 0) ? 32'd1 : 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("midrst_pready", {31'b0, PREADY}, 32'd0);
    checkOutput("midrst_pslverr", {31'b0, PSLVERR}, 32'd0);
    checkOutput("midrst_prdata", {11'b0, PRDATA}, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    doRead("postrst_rd10", 8'h10, 21'h0, 1'b0);
    doRead("postrst_rd05", 8'h05, 21'h0, 1'b0);

    // Master abort in the access phase of a write to 0x08
    doWrite("abort_pre", 8'h08, 21'h12345, 1'b0);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h08; PWDATA = 21'h0DEAD;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b1;
    @(negedge clk);
    checkOutput("abort_pready", {31'b0, PREADY}, 32'd0);
    // Without a setup phase this must not complete if the FSM went idle
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b1;
    @(negedge clk);
    checkOutput("abort_idle_pready", {31'b0, PREADY}, 32'd0);
    idleCycle();
    doRead("abort_rd08", 8'h08, 21'h12345, 1'b0);

    // Access strobe without setup from IDLE is ignored
    doWrite("nosetup_pre", 8'h00, 21'h00777, 1'b0);
    idleCycle();
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 21'h1FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("nosetup_pready", {31'b0, PREADY}, 32'd0);
      @(posedge clk); #1;
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    doRead("nosetup_rd00", 8'h00, 21'h00777, 1'b0);
    idleCycle();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
